// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM read path.
//   SPRITE_ROM_LATENCY : cycles from ROM address to palette output (2 image + 2 palette)
//   SPRITE_ADDR_WIDTH  : image ROM address width
//   PIXEL_WIDTH        : palette ROM output width
package sprite_pkg;

    localparam int unsigned SPRITE_ROM_LATENCY = 4;
    localparam int unsigned SPRITE_ADDR_WIDTH  = 16;
    localparam int unsigned PIXEL_WIDTH        = 12;

    typedef logic [PIXEL_WIDTH-1:0]       pixel_t;
    typedef logic [SPRITE_ADDR_WIDTH-1:0] rom_addr_t;

endpackage : sprite_pkg

// File: rtl/sprite_rom_arbiter_if.sv
// Request/ROM/response bundle between the sprite requesters, the arbiter and the ROM pair.
//   slave  : arbiter side (takes requests and ROM data, drives grants, ROM address, responses)
//   master : requester/ROM side
interface sprite_rom_arbiter_if
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = SPRITE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PIXEL_WIDTH
);

    logic [NUM_REQ-1:0]                 req_valid_in;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_in;
    logic [NUM_REQ-1:0]                 req_ready_out;
    logic [ADDR_WIDTH-1:0]              rom_addr_out;
    logic                               rom_rd_out;
    logic [DATA_WIDTH-1:0]              rom_data_in;
    logic [NUM_REQ-1:0]                 rsp_valid_out;
    logic [DATA_WIDTH-1:0]              rsp_data_out;
    logic                               busy_out;

    modport slave (
        input  req_valid_in, req_addr_in, rom_data_in,
        output req_ready_out, rom_addr_out, rom_rd_out, rsp_valid_out, rsp_data_out, busy_out
    );

    modport master (
        output req_valid_in, req_addr_in, rom_data_in,
        input  req_ready_out, rom_addr_out, rom_rd_out, rsp_valid_out, rsp_data_out, busy_out
    );

endinterface : sprite_rom_arbiter_if

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
//   clk, rst_n   : clock, async active-low reset
//   req          : request vector
//   advance      : allows the pointer to move past the granted requester
//   grant_c      : one-hot grant (combinational)
//   grant_idx_c  : index of the granted requester (valid when grant_c != 0)
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] grant_idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next_c;
    logic [IDX_W:0]   cand_c;
    logic             found_c;

    // Search P, P+1, ... wrapping mod N; first requester seen wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found_c     = 1'b0;
        cand_c      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand_c = {1'b0, ptr_q} + (IDX_W+1)'(off);
            if (cand_c >= (IDX_W+1)'(N)) begin
                cand_c = cand_c - (IDX_W+1)'(N);
            end
            if (!found_c && req[cand_c[IDX_W-1:0]]) begin
                found_c     = 1'b1;
                grant_idx_c = cand_c[IDX_W-1:0];
            end
        end
        if (found_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
        ptr_next_c = (grant_idx_c == IDX_W'(N - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end

    // Pointer moves just past the winner; held when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && found_c) begin
            ptr_q <= ptr_next_c;
        end
    end

endmodule : rr_arbiter

// File: rtl/sprite_rom_arbiter.sv
// Shares one fixed-latency sprite ROM read path between NUM_REQ pixel requesters.
// Round-robin grant, address mux to the image ROM, and a tag pipeline matched to the
// ROM latency so each returned pixel is flagged to the requester that issued it.
//   pixel_clk_in : pixel clock
//   rst_n_in     : async active-low reset
//   bus          : requests, ROM address/data, tagged responses, busy
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = SPRITE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PIXEL_WIDTH,
    parameter int unsigned LATENCY    = SPRITE_ROM_LATENCY  // must be >= 2
) (
    input logic                 pixel_clk_in,
    input logic                 rst_n_in,
    sprite_rom_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]              grant_c;
    logic [IDX_W-1:0]                grant_idx_c;
    logic                            rd_c;
    logic [ADDR_WIDTH-1:0]           addr_mux_c;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [LATENCY-1:0][NUM_REQ-1:0] tag_q;
    logic [DATA_WIDTH-1:0]           rsp_data_c;

    // A grant only ever goes to a valid requester, so every grant is a transfer.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk         (pixel_clk_in),
        .rst_n       (rst_n_in),
        .req         (bus.req_valid_in),
        .advance     (1'b1),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign rd_c       = |grant_c;
    assign addr_mux_c = bus.req_addr_in[grant_idx_c];

    // ROM address holds its last granted value between reads.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q <= '0;
        end else if (rd_c) begin
            addr_q <= addr_mux_c;
        end
    end

    // Tag pipeline: the grant vector travels alongside the read through the ROM pair.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[LATENCY-2:0], grant_c};
        end
    end

    assign rsp_data_c = bus.rom_data_in;

    assign bus.req_ready_out = grant_c;
    assign bus.rom_rd_out    = rd_c;
    assign bus.rom_addr_out  = rd_c ? addr_mux_c : addr_q;
    assign bus.rsp_valid_out = tag_q[LATENCY-1];
    assign bus.rsp_data_out  = rsp_data_c;
    assign bus.busy_out      = |tag_q;

endmodule : sprite_rom_arbiter

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one sprite ROM read path (image BROM followed by palette BROM, fixed read latency) between several pixel requesters, such as multiple on-screen sprites or a sprite plus an overlay. It grants at most one request per cycle using round-robin, drives the ROM address, and tracks the grant ID through a latency-matched tag pipeline. Each returned 12-bit pixel is therefore flagged to the requester that issued it. It sits between the sprite position/compositing logic and the shared ROM pair in the pixel clock domain.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 16: ROM address width (WIDTH*HEIGHT = 65536 entries).
- DATA_WIDTH, 12: pixel width returned by the palette ROM.
- LATENCY, 4: cycles from address presented to ROM until rom_data_in is valid (2 image + 2 palette).

Ports:
- pixel_clk_in  in  1  pixel clock; all logic on its rising edge.
- rst_n_in  in  1  reset, asynchronous, active-low.
- req_valid_in  in  NUM_REQ  per-requester read request.
- req_addr_in  in  NUM_REQ x ADDR_WIDTH  per-requester ROM address.
- req_ready_out  out  NUM_REQ  one-hot grant; the request is accepted this cycle.
- rom_addr_out  out  ADDR_WIDTH  address to image BROM.
- rom_rd_out  out  1  high when rom_addr_out carries a granted read.
- rom_data_in  in  DATA_WIDTH  palette BROM output.
- rsp_valid_out  out  NUM_REQ  one-hot; the response on rsp_data_out belongs to this requester.
- rsp_data_out  out  DATA_WIDTH  returned pixel, shared by all requesters.
- busy_out  out  1  high while any read is in flight.

## Operation
- Handshake: valid/ready. A requester holds valid and addr stable until it sees ready. Transfer occurs when valid & ready are both high in the same cycle. ready is combinational from valid and the priority pointer. ready may be high only when the matching valid is high.
- Arbitration: round-robin. Search order starts at priority pointer P: P, P+1, ... wrapping mod NUM_REQ. The first valid requester is granted.
- On a grant to requester g, P <= (g+1) mod NUM_REQ. With no grant, P is unchanged.
- At most one grant per cycle; a grant is possible every cycle, so throughput is 1 read/cycle.
- Fairness: a requester holding valid is granted within NUM_REQ cycles.
- rom_addr_out = req_addr_in[g] in a grant cycle; otherwise it holds its last value. rom_rd_out = |req_ready_out.
- Tag pipeline: LATENCY stages, each holding a one-hot NUM_REQ vector. Stage 0 <= req_ready_out; stage i <= stage i-1.
- rsp_valid_out = stage LATENCY-1. rsp_data_out = rom_data_in (passthrough, aligned to the tag tail).
- busy_out = OR of all tag stages.
- Requester IDs and ordering: responses return in grant order. There is no reordering and no backpressure on responses; requesters must always accept.

## Timing
- Reset (async assert, sync release handled upstream): P=0, all tag stages 0, rom_addr_out=0.
- Reset values of outputs: rsp_valid_out=0, busy_out=0, rom_rd_out=0, req_ready_out=0.
- Reset mid-operation: all in-flight tags are dropped; no rsp_valid_out pulses follow for those reads.
- Latency: a grant at cycle N gives rsp_valid_out for that requester at cycle N+LATENCY, exactly one cycle wide.
- Simultaneous events: a new grant and a response retiring in the same cycle are independent. busy_out stays high if either is present.
- Wrap-around: when P = NUM_REQ-1 and requester NUM_REQ-1 is granted, P returns to 0.
- No valid inputs: no grant, P held, rom_rd_out=0, and the pipe shifts in zeros.

## Structure
- Shared package sprite_pkg holds:
  - constants SPRITE_ROM_LATENCY=4, SPRITE_ADDR_WIDTH=16, PIXEL_WIDTH=12;
  - typedef pixel_t (12-bit);
  - typedef rom_addr_t.
- Sub-module rr_arbiter (parameter N) is natural:
  - inputs: request vector, clock, reset, advance enable;
  - output: one-hot grant;
  - owns pointer P.
- sprite_rom_arbiter instantiates rr_arbiter plus the address mux and the tag shift register.

## Test plan
- Single request: req_valid_in=0001, addr=0x0123 at cycle 5 -> ready=0001 at cycle 5, rom_addr_out=0x0123, rsp_valid_out=0001 at cycle 9 with rsp_data_out = ROM model[0x0123].
- All four valid continuously for 8 cycles from reset -> grants 0001,0010,0100,1000,0001,... and responses appear in the same order starting 4 cycles later, one per cycle.
- Requesters 1 and 3 valid, P=2 -> grant 3 first, then 1, then 3. P ends at 2 after two cycles.
- Requester 2 holds valid while 0 and 1 re-request every cycle -> requester 2 granted within 4 cycles of asserting.
- rst_n_in pulsed low with 3 reads in flight -> rsp_valid_out, busy_out, and P all go to 0 immediately, and no responses emerge after release.
- Idle gap: grants at cycles 10 and 13 only -> busy_out high over cycles 11-17, rsp_valid_out pulses at 14 and 17, and rom_rd_out is low in cycles 11-12.
